ped_walk_ctrl: RTL

PED_WALK_CTRL -- requirements
Module: ped_walk_ctrl

---
 rtl/ped_walk_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ped_walk_ctrl.sv
// Pedestrian walk controller: follows the upstream traffic light and grants WALK/FLASH phases on request.
// All outputs are registered (one-cycle latency); there is no backpressure, and the inputs are sampled every cycle.
module ped_walk_ctrl #(
    parameter logic [7:0] MIN_START    = 8'd24,
    parameter logic [7:0] FLASH_LEN    = 8'd8,
    parameter logic [3:0] FLASH_PERIOD = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light_sign,
    input  logic [7:0] time_left,
    input  logic       ped_btn,
    output logic       walk_lamp,
    output logic       dw_lamp,
    output logic [7:0] countdown,
    output logic       req_pending,
    output logic [1:0] ped_state,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WALK  = 2'd2,
        ST_FLASH = 2'd3
    } state_e;

    localparam logic [1:0] LS_RED     = 2'd0;
    localparam logic [1:0] LS_ILLEGAL = 2'd3;

    state_e     state_q, state_d;
    logic       walk_q, walk_d;
    logic       dw_q, dw_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       fault_q, fault_d;
    logic [3:0] blink_q, blink_d;
    logic       btn_q;
    logic       req;
    logic       forced;

    assign req = ped_btn & ~btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
            blink_q <= 4'd0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
            blink_q <= blink_d;
            btn_q   <= ped_btn;
        end
    end

    // A latched request left over after a forced IDLE re-enters WAIT on its own.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        fault_d = fault_q;
        forced  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req || pend_q) begin
                    state_d = ST_WAIT;
                    pend_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (light_sign == LS_RED && time_left >= MIN_START) begin
                    state_d = ST_WALK;
                    pend_d  = 1'b0;
                end
            end
            ST_WALK: begin
                if (light_sign != LS_RED) begin
                    forced = 1'b1;
                end else if (time_left <= FLASH_LEN) begin
                    state_d = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (req) begin
                    pend_d = 1'b1;
                end
                if (light_sign != LS_RED) begin
                    state_d = (pend_q || req) ? ST_WAIT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (light_sign == LS_ILLEGAL) begin
            forced = 1'b1;
        end
        if (forced) begin
            state_d = ST_IDLE;
            fault_d = 1'b1;
            pend_d  = pend_q | req;
        end
    end

    always_comb begin
        walk_d  = 1'b0;
        dw_d    = 1'b1;
        cnt_d   = 8'd0;
        blink_d = 4'd0;
        case (state_d)
            ST_WALK: begin
                walk_d = 1'b1;
                dw_d   = 1'b0;
                cnt_d  = time_left;
            end
            ST_FLASH: begin
                cnt_d = time_left;
                if (state_q != ST_FLASH) begin
                    dw_d    = 1'b1;
                    blink_d = 4'd0;
                end else if (blink_q == FLASH_PERIOD - 4'd1) begin
                    dw_d    = ~dw_q;
                    blink_d = 4'd0;
                end else begin
                    dw_d    = dw_q;
                    blink_d = blink_q + 4'd1;
                end
            end
            default: begin
                walk_d = 1'b0;
                dw_d   = 1'b1;
            end
        endcase
    end

    assign walk_lamp   = walk_q;
    assign dw_lamp     = dw_q;
    assign countdown   = cnt_q;
    assign req_pending = pend_q;
    assign ped_state   = state_q;
    assign fault       = fault_q;

endmodule
